// File: rtl/password_pkg.sv
// Shared types, display codes and digit-to-segment-code helper for the
// password checker. MASK_DIGITS_EN shows entered digits as STAR codes.
package password_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } state_t;

  localparam logic [4:0] BLANK = 5'h1F;
  localparam logic [4:0] DASH  = 5'h10;
  localparam logic [4:0] OPEN  = 5'h11;
  localparam logic [4:0] ERR   = 5'h12;
  localparam logic [4:0] STAR  = 5'h13;

`ifdef MASK_DIGITS_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  function automatic logic [4:0] digit_code(
    input logic [3:0] d
  );
    return MASK ? STAR : {1'b0, d};
  endfunction

endpackage

// File: rtl/password_check_fsm_timer.sv
// cycle_timer: loadable down-counter, holds at zero.
// Ports: clk, reset, load, load_val -> done (count == 0).
module cycle_timer #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/password_check_fsm.sv
// Collects a code one digit per enter pulse, compares it with stored_pw and
// drives unlock/fail/lockout status plus a 4 x 5-bit display word.
// Ports: clk, reset, enter_pulse, digit_in, stored_pw, pw_valid ->
//   unlocked, fail, locked_out, tries, entry_idx, disp_code.
// Build option: MASK_DIGITS_EN shows entered digits as STAR.
module password_check_fsm
  import password_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 50_000_000,
  parameter int LOCKOUT_CYCLES = 250_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enter_pulse,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] stored_pw,
  input  logic                          pw_valid,
  output logic                          unlocked,
  output logic                          fail,
  output logic                          locked_out,
  output logic [1:0]                    tries,
  output logic [1:0]                    entry_idx,
  output logic [5*NUM_DIGITS-1:0]       disp_code
);

  localparam int TW = $clog2(LOCKOUT_CYCLES);

  state_t state_q, state_d;

  // Slot 0 lives in the top digit so the buffer lines up with stored_pw.
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] entry_buf, buf_d;

  logic [1:0]              idx_d;
  logic [1:0]              tries_d;
  logic [1:0]              tries_inc;
  logic                    fail_d;
  logic                    match;
  logic                    t_load;
  logic [TW-1:0]           t_val;
  logic                    t_done;
  logic [5*NUM_DIGITS-1:0] disp_d;

  cycle_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  assign match = (entry_buf == stored_pw);

  // Saturating increment so tries never wraps past MAX_TRIES.
  assign tries_inc = (tries == 2'(MAX_TRIES)) ? tries : tries + 2'd1;

  always_comb begin
    state_d = state_q;
    buf_d   = entry_buf;
    idx_d   = entry_idx;
    tries_d = tries;
    fail_d  = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
    unique case (state_q)
      IDLE: begin
        if (enter_pulse && pw_valid) begin
          buf_d[NUM_DIGITS-1] = digit_in;
          idx_d   = 2'd1;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (!pw_valid) begin
          buf_d   = '0;
          idx_d   = 2'd0;
          state_d = IDLE;
        end else if (enter_pulse) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(entry_idx) == i) begin
              buf_d[NUM_DIGITS-1-i] = digit_in;
            end
          end
          idx_d = entry_idx + 2'd1;
          if (int'(entry_idx) == NUM_DIGITS - 1) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        buf_d = '0;
        idx_d = 2'd0;
        if (!pw_valid) begin
          state_d = IDLE;
        end else if (match) begin
          state_d = UNLOCKED;
          tries_d = 2'd0;
          t_load  = 1'b1;
          t_val   = TW'(UNLOCK_CYCLES - 1);
        end else begin
          fail_d  = 1'b1;
          tries_d = tries_inc;
          if (tries_inc == 2'(MAX_TRIES)) begin
            state_d = LOCKOUT;
            t_load  = 1'b1;
            t_val   = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      UNLOCKED: begin
        if (t_done) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (t_done) begin
          state_d = IDLE;
          tries_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display follows the current (registered) state, so it lags by a cycle.
  always_comb begin
    disp_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      unique case (state_q)
        IDLE:     disp_d[5*(NUM_DIGITS-1-i) +: 5] = DASH;
        ENTRY: begin
          if (i < int'(entry_idx)) begin
            disp_d[5*(NUM_DIGITS-1-i) +: 5] =
              digit_code(4'(entry_buf[NUM_DIGITS-1-i]));
          end else begin
            disp_d[5*(NUM_DIGITS-1-i) +: 5] = DASH;
          end
        end
        CHECK: begin
          disp_d[5*(NUM_DIGITS-1-i) +: 5] =
            digit_code(4'(entry_buf[NUM_DIGITS-1-i]));
        end
        UNLOCKED: disp_d[5*(NUM_DIGITS-1-i) +: 5] = OPEN;
        LOCKOUT:  disp_d[5*(NUM_DIGITS-1-i) +: 5] = ERR;
        default:  disp_d[5*(NUM_DIGITS-1-i) +: 5] = BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      entry_buf  <= '0;
      entry_idx  <= 2'd0;
      tries      <= 2'd0;
      fail       <= 1'b0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      disp_code  <= {NUM_DIGITS{BLANK}};
    end else begin
      state_q    <= state_d;
      entry_buf  <= buf_d;
      entry_idx  <= idx_d;
      tries      <= tries_d;
      fail       <= fail_d;
      unlocked   <= (state_d == UNLOCKED);
      locked_out <= (state_d == LOCKOUT);
      disp_code  <= disp_d;
    end
  end

endmodule

// File: tb/tb_password_check_fsm.sv
// Directed bench for password_check_fsm with short unlock/lockout timers.
// Honours MASK_DIGITS_EN for the entry display expectation.
module tb_password_check_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enter_pulse = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic [15:0] stored_pw = 16'h1234;
  logic        pw_valid = 1'b1;
  logic        unlocked;
  logic        fail;
  logic        locked_out;
  logic [1:0]  tries;
  logic [1:0]  entry_idx;
  logic [19:0] disp_code;

  int n_cmp = 0;
  int n_err = 0;
  int unl_cnt = 0;
  int lo_cnt = 0;

  localparam logic [19:0] D_BLANK = 20'hFFFFF;
  localparam logic [19:0] D_DASH  = {4{5'h10}};
  localparam logic [19:0] D_OPEN  = {4{5'h11}};
  localparam logic [19:0] D_ERR   = {4{5'h12}};
`ifdef MASK_DIGITS_EN
  localparam logic [19:0] D_TWO = {5'h13, 5'h13, 5'h10, 5'h10};
`else
  localparam logic [19:0] D_TWO = {5'h01, 5'h02, 5'h10, 5'h10};
`endif

  password_check_fsm #(
    .NUM_DIGITS     (4),
    .DIGIT_W        (4),
    .MAX_TRIES      (3),
    .UNLOCK_CYCLES  (8),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enter_pulse (enter_pulse),
    .digit_in    (digit_in),
    .stored_pw   (stored_pw),
    .pw_valid    (pw_valid),
    .unlocked    (unlocked),
    .fail        (fail),
    .locked_out  (locked_out),
    .tries       (tries),
    .entry_idx   (entry_idx),
    .disp_code   (disp_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (unlocked) unl_cnt++;
    if (locked_out) lo_cnt++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enter_pulse = 1'b0;
    pw_valid = 1'b1;
    stored_pw = 16'h1234;
    @(negedge clk);
    unl_cnt = 0;
    lo_cnt = 0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    digit_in = d;
    enter_pulse = 1'b1;
    @(negedge clk);
    enter_pulse = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      press(code[15-4*i -: 4]);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (unlocked !== 1'b0) begin n_err++; $display("FAIL rst_unlocked got %b exp 0", unlocked); end
    n_cmp++; if (fail !== 1'b0) begin n_err++; $display("FAIL rst_fail got %b exp 0", fail); end
    n_cmp++; if (locked_out !== 1'b0) begin n_err++; $display("FAIL rst_locked got %b exp 0", locked_out); end
    n_cmp++; if (tries !== 2'd0) begin n_err++; $display("FAIL rst_tries got %0d exp 0", tries); end
    n_cmp++; if (entry_idx !== 2'd0) begin n_err++; $display("FAIL rst_idx got %0d exp 0", entry_idx); end
    n_cmp++; if (disp_code !== D_BLANK) begin n_err++; $display("FAIL rst_disp got %h exp %h", disp_code, D_BLANK); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (disp_code !== D_DASH) begin n_err++; $display("FAIL idle_disp got %h exp %h", disp_code, D_DASH); end
  endtask

  task automatic test_idle_ignore();
    do_reset();
    pw_valid = 1'b0;
    press(4'd1);
    n_cmp++; if (entry_idx !== 2'd0) begin n_err++; $display("FAIL invalid_idx got %0d exp 0", entry_idx); end
    pw_valid = 1'b1;
  endtask

  task automatic test_correct();
    do_reset();
    enter_code(16'h1234);
    @(negedge clk);
    n_cmp++; if (unlocked !== 1'b1) begin n_err++; $display("FAIL ok_unlocked got %b exp 1", unlocked); end
    n_cmp++; if (tries !== 2'd0) begin n_err++; $display("FAIL ok_tries got %0d exp 0", tries); end
    n_cmp++; if (fail !== 1'b0) begin n_err++; $display("FAIL ok_fail got %b exp 0", fail); end
    @(negedge clk);
    n_cmp++; if (disp_code !== D_OPEN) begin n_err++; $display("FAIL ok_disp got %h exp %h", disp_code, D_OPEN); end
    repeat (20) @(negedge clk);
    n_cmp++; if (unl_cnt !== 8) begin n_err++; $display("FAIL ok_hold got %0d exp 8", unl_cnt); end
    n_cmp++; if (unlocked !== 1'b0) begin n_err++; $display("FAIL ok_after got %b exp 0", unlocked); end
    n_cmp++; if (disp_code !== D_DASH) begin n_err++; $display("FAIL ok_after_disp got %h exp %h", disp_code, D_DASH); end
  endtask

  task automatic test_wrong();
    do_reset();
    enter_code(16'h1235);
    @(negedge clk);
    n_cmp++; if (fail !== 1'b1) begin n_err++; $display("FAIL bad_fail got %b exp 1", fail); end
    n_cmp++; if (tries !== 2'd1) begin n_err++; $display("FAIL bad_tries got %0d exp 1", tries); end
    n_cmp++; if (unlocked !== 1'b0) begin n_err++; $display("FAIL bad_unlocked got %b exp 0", unlocked); end
    @(negedge clk);
    n_cmp++; if (fail !== 1'b0) begin n_err++; $display("FAIL bad_fail_end got %b exp 0", fail); end
    n_cmp++; if (entry_idx !== 2'd0) begin n_err++; $display("FAIL bad_idx got %0d exp 0", entry_idx); end
    n_cmp++; if (disp_code !== D_DASH) begin n_err++; $display("FAIL bad_disp got %h exp %h", disp_code, D_DASH); end
  endtask

  task automatic test_lockout();
    do_reset();
    repeat (2) begin
      enter_code(16'h1235);
      repeat (2) @(negedge clk);
    end
    n_cmp++; if (tries !== 2'd2) begin n_err++; $display("FAIL lo_pre_tries got %0d exp 2", tries); end
    enter_code(16'h9999);
    @(negedge clk);
    n_cmp++; if (locked_out !== 1'b1) begin n_err++; $display("FAIL lo_locked got %b exp 1", locked_out); end
    n_cmp++; if (fail !== 1'b1) begin n_err++; $display("FAIL lo_fail got %b exp 1", fail); end
    n_cmp++; if (tries !== 2'd3) begin n_err++; $display("FAIL lo_tries got %0d exp 3", tries); end
    @(negedge clk);
    n_cmp++; if (disp_code !== D_ERR) begin n_err++; $display("FAIL lo_disp got %h exp %h", disp_code, D_ERR); end
    press(4'd1);
    n_cmp++; if (entry_idx !== 2'd0) begin n_err++; $display("FAIL lo_ignore got %0d exp 0", entry_idx); end
    enter_code(16'h1234);
    n_cmp++; if (unlocked !== 1'b0) begin n_err++; $display("FAIL lo_no_unlock got %b exp 0", unlocked); end
    repeat (20) @(negedge clk);
    n_cmp++; if (lo_cnt !== 16) begin n_err++; $display("FAIL lo_hold got %0d exp 16", lo_cnt); end
    n_cmp++; if (tries !== 2'd0) begin n_err++; $display("FAIL lo_after_tries got %0d exp 0", tries); end
    n_cmp++; if (unl_cnt !== 0) begin n_err++; $display("FAIL lo_after_unl got %0d exp 0", unl_cnt); end
  endtask

  task automatic test_success_clears();
    do_reset();
    repeat (2) begin
      enter_code(16'h4321);
      repeat (2) @(negedge clk);
    end
    enter_code(16'h1234);
    @(negedge clk);
    n_cmp++; if (unlocked !== 1'b1) begin n_err++; $display("FAIL sc_unlocked got %b exp 1", unlocked); end
    n_cmp++; if (tries !== 2'd0) begin n_err++; $display("FAIL sc_tries got %0d exp 0", tries); end
  endtask

  task automatic test_abort();
    do_reset();
    enter_code(16'h0000);
    repeat (2) @(negedge clk);
    press(4'd1);
    press(4'd2);
    n_cmp++; if (entry_idx !== 2'd2) begin n_err++; $display("FAIL ab_idx2 got %0d exp 2", entry_idx); end
    @(negedge clk);
    n_cmp++; if (disp_code !== D_TWO) begin n_err++; $display("FAIL ab_disp got %h exp %h", disp_code, D_TWO); end
    pw_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (entry_idx !== 2'd0) begin n_err++; $display("FAIL ab_idx got %0d exp 0", entry_idx); end
    n_cmp++; if (fail !== 1'b0) begin n_err++; $display("FAIL ab_fail got %b exp 0", fail); end
    n_cmp++; if (tries !== 2'd1) begin n_err++; $display("FAIL ab_tries got %0d exp 1", tries); end
    @(negedge clk);
    n_cmp++; if (disp_code !== D_DASH) begin n_err++; $display("FAIL ab_disp2 got %h exp %h", disp_code, D_DASH); end
    pw_valid = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      digit_in = (i == 4) ? 4'd9 : 4'(i + 1);
      enter_pulse = 1'b1;
    end
    @(negedge clk);
    enter_pulse = 1'b0;
    n_cmp++; if (unlocked !== 1'b1) begin n_err++; $display("FAIL b2b_unlocked got %b exp 1", unlocked); end
    n_cmp++; if (entry_idx !== 2'd0) begin n_err++; $display("FAIL b2b_idx got %0d exp 0", entry_idx); end
    n_cmp++; if (fail !== 1'b0) begin n_err++; $display("FAIL b2b_fail got %b exp 0", fail); end
  endtask

  task automatic test_async_reset();
    do_reset();
    enter_code(16'h1234);
    repeat (3) @(negedge clk);
    n_cmp++; if (unlocked !== 1'b1) begin n_err++; $display("FAIL ar_pre got %b exp 1", unlocked); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (unlocked !== 1'b0) begin n_err++; $display("FAIL ar_unlocked got %b exp 0", unlocked); end
    n_cmp++; if (disp_code !== D_BLANK) begin n_err++; $display("FAIL ar_disp got %h exp %h", disp_code, D_BLANK); end
    n_cmp++; if (tries !== 2'd0) begin n_err++; $display("FAIL ar_tries got %0d exp 0", tries); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_correct();
    test_wrong();
    test_lockout();
    test_success_clears();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
